// File: rtl/csr_mmio_arbiter.sv
// csr_mmio_arbiter
// Shares one Avalon-MM CSR target between two requesters (req0 = host MMIO,
// req1 = ASP management). Round-robin grant, one command outstanding, read
// data routed only to the issuing requester, and a read timeout that
// synthesizes BADADDR_DATA so every accepted read completes.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   reqN_address/read/write/
//     writedata                  requester N command inputs (N = 0,1)
//   reqN_waitrequest             low = command accepted this cycle (combinational)
//   reqN_readdata/readdatavalid  registered read response to requester N
//   csr_address/read/write/
//     writedata                  registered command to the target
//   csr_waitrequest              target backpressure
//   csr_readdata/readdatavalid   target read response
//   timeout_count                saturating count of synthesized responses
module csr_mmio_arbiter #(
  parameter int unsigned          ADDR_W       = 16,
  parameter int unsigned          DATA_W       = 64,
  parameter int unsigned          RD_TIMEOUT   = 256,
  parameter logic [DATA_W-1:0]    BADADDR_DATA = 64'hBAADBEEF_DEADBEEF
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] req0_address,
  input  logic              req0_read,
  input  logic              req0_write,
  input  logic [DATA_W-1:0] req0_writedata,
  output logic              req0_waitrequest,
  output logic [DATA_W-1:0] req0_readdata,
  output logic              req0_readdatavalid,

  input  logic [ADDR_W-1:0] req1_address,
  input  logic              req1_read,
  input  logic              req1_write,
  input  logic [DATA_W-1:0] req1_writedata,
  output logic              req1_waitrequest,
  output logic [DATA_W-1:0] req1_readdata,
  output logic              req1_readdatavalid,

  output logic [ADDR_W-1:0] csr_address,
  output logic              csr_read,
  output logic              csr_write,
  output logic [DATA_W-1:0] csr_writedata,
  input  logic              csr_waitrequest,
  input  logic [DATA_W-1:0] csr_readdata,
  input  logic              csr_readdatavalid,

  output logic [15:0]       timeout_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(RD_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [15:0]         timer_q, timer_d;
  logic [15:0]         tcnt_q, tcnt_d;
  logic                rv0_q, rv0_d;
  logic                rv1_q, rv1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;

  logic                pend0, pend1;
  logic                grant_vld;
  logic                grant_idx;
  logic                sel_read;

  // Grant decision: only in IDLE; on contention the requester not granted
  // last time wins.
  always_comb begin
    pend0     = req0_read | req0_write;
    pend1     = req1_read | req1_write;
    grant_vld = (state_q == IDLE) && (pend0 || pend1);
    grant_idx = (pend0 && pend1) ? ~last_q : pend1;
  end

  // Gated with reset_n so no command is accepted while reset is asserted.
  assign req0_waitrequest = ~(reset_n & grant_vld & ~grant_idx);
  assign req1_waitrequest = ~(reset_n & grant_vld &  grant_idx);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    last_d   = last_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    tcnt_d   = tcnt_q;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    sel_read = grant_idx ? req1_read : req0_read;

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d = grant_idx;
          last_d  = grant_idx;
          addr_d  = grant_idx ? req1_address   : req0_address;
          wdata_d = grant_idx ? req1_writedata : req0_writedata;
          // Read takes priority if a requester illegally raises both.
          rd_d    = sel_read;
          wr_d    = ~sel_read;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (!csr_waitrequest) begin
          if (rd_q) begin
            rd_d    = 1'b0;
            timer_d = '0;
            state_d = RD_WAIT;
          end else begin
            wr_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end

      RD_WAIT: begin
        timer_d = timer_q + 16'd1;
        // Real data takes precedence over a timeout in the same cycle.
        if (csr_readdatavalid) begin
          if (owner_q) begin
            rdata1_d = csr_readdata;
            rv1_d    = 1'b1;
          end else begin
            rdata0_d = csr_readdata;
            rv0_d    = 1'b1;
          end
          state_d = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          if (owner_q) begin
            rdata1_d = BADADDR_DATA;
            rv1_d    = 1'b1;
          end else begin
            rdata0_d = BADADDR_DATA;
            rv0_d    = 1'b1;
          end
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      timer_q  <= '0;
      tcnt_q   <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      tcnt_q   <= tcnt_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign csr_address        = addr_q;
  assign csr_read           = rd_q;
  assign csr_write          = wr_q;
  assign csr_writedata      = wdata_q;
  assign req0_readdata      = rdata0_q;
  assign req0_readdatavalid = rv0_q;
  assign req1_readdata      = rdata1_q;
  assign req1_readdatavalid = rv1_q;
  assign timeout_count      = tcnt_q;

endmodule

// File: tb/tb_csr_mmio_arbiter.sv
// Directed self-checking bench for csr_mmio_arbiter (RD_TIMEOUT = 8).
// Inputs are driven and outputs sampled 1 ns after the rising edge.
module tb_csr_mmio_arbiter;

  localparam logic [63:0] BAD = 64'hBAADBEEF_DEADBEEF;

  logic        clk;
  logic        reset_n;
  logic [15:0] req0_address, req1_address;
  logic        req0_read, req0_write, req1_read, req1_write;
  logic [63:0] req0_writedata, req1_writedata;
  logic        req0_waitrequest, req1_waitrequest;
  logic [63:0] req0_readdata, req1_readdata;
  logic        req0_readdatavalid, req1_readdatavalid;
  logic [15:0] csr_address;
  logic        csr_read, csr_write;
  logic [63:0] csr_writedata;
  logic        csr_waitrequest;
  logic [63:0] csr_readdata;
  logic        csr_readdatavalid;
  logic [15:0] timeout_count;

  int unsigned n_cmp;
  int unsigned n_err;

  csr_mmio_arbiter #(
    .ADDR_W      (16),
    .DATA_W      (64),
    .RD_TIMEOUT  (8),
    .BADADDR_DATA(BAD)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req0_address      (req0_address),
    .req0_read         (req0_read),
    .req0_write        (req0_write),
    .req0_writedata    (req0_writedata),
    .req0_waitrequest  (req0_waitrequest),
    .req0_readdata     (req0_readdata),
    .req0_readdatavalid(req0_readdatavalid),
    .req1_address      (req1_address),
    .req1_read         (req1_read),
    .req1_write        (req1_write),
    .req1_writedata    (req1_writedata),
    .req1_waitrequest  (req1_waitrequest),
    .req1_readdata     (req1_readdata),
    .req1_readdatavalid(req1_readdatavalid),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_waitrequest   (csr_waitrequest),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .timeout_count     (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_read = 1'b0; req0_write = 1'b0; req0_address = '0; req0_writedata = '0;
    req1_read = 1'b0; req1_write = 1'b0; req1_address = '0; req1_writedata = '0;
    csr_waitrequest = 1'b0; csr_readdata = '0; csr_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    reset_n = 1'b0;
    tick();
    // Reset values, with a pending request that must not be accepted.
    req0_read = 1'b1;
    #1;
    check("rst_wait0", 64'(req0_waitrequest), 64'd1);
    check("rst_wait1", 64'(req1_waitrequest), 64'd1);
    check("rst_csr_read", 64'(csr_read), 64'd0);
    check("rst_csr_write", 64'(csr_write), 64'd0);
    check("rst_csr_addr", 64'(csr_address), 64'd0);
    check("rst_csr_wdata", csr_writedata, 64'd0);
    check("rst_rv0", 64'(req0_readdatavalid), 64'd0);
    check("rst_rd0", req0_readdata, 64'd0);
    check("rst_tcnt", 64'(timeout_count), 64'd0);
    do_reset();

    // ---- Single read from req0, 1-cycle target ----
    req0_read = 1'b1; req0_address = 16'h0030;             // T
    #1;
    check("rd_grant0", 64'(req0_waitrequest), 64'd0);
    check("rd_nogrant1", 64'(req1_waitrequest), 64'd1);
    tick();                                                // T+1
    req0_read = 1'b0;
    #1;
    check("rd_csr_read", 64'(csr_read), 64'd1);
    check("rd_csr_addr", 64'(csr_address), 64'h30);
    check("rd_busy0", 64'(req0_waitrequest), 64'd1);
    tick();                                                // T+2
    check("rd_csr_read_clr", 64'(csr_read), 64'd0);
    csr_readdatavalid = 1'b1; csr_readdata = 64'h1234;
    tick();                                                // T+3
    csr_readdatavalid = 1'b0; csr_readdata = '0;
    check("rd_rv0", 64'(req0_readdatavalid), 64'd1);
    check("rd_data0", req0_readdata, 64'h1234);
    check("rd_rv1", 64'(req1_readdatavalid), 64'd0);
    tick();                                                // T+4
    check("rd_rv0_pulse", 64'(req0_readdatavalid), 64'd0);

    // ---- Both requesters write continuously ----
    do_reset();
    begin
      int unsigned idx0, idx1;
      int unsigned g;
      idx0 = 0; idx1 = 0;
      req0_write = 1'b1; req0_address = 16'h0100; req0_writedata = 64'hA000;
      req1_write = 1'b1; req1_address = 16'h0200; req1_writedata = 64'hB000;
      for (int k = 0; k < 4; k++) begin
        g = k % 2;
        #1;
        check("wr_wait0", 64'(req0_waitrequest), (g == 0) ? 64'd0 : 64'd1);
        check("wr_wait1", 64'(req1_waitrequest), (g == 1) ? 64'd0 : 64'd1);
        tick();
        check("wr_csr_write", 64'(csr_write), 64'd1);
        check("wr_csr_addr", 64'(csr_address), (g == 0) ? 64'h100 : 64'h200);
        check("wr_csr_wdata", csr_writedata,
              (g == 0) ? 64'hA000 + 64'(idx0) : 64'hB000 + 64'(idx1));
        check("wr_issue_wait0", 64'(req0_waitrequest), 64'd1);
        if (g == 0) begin
          idx0++;
          req0_writedata = 64'hA000 + 64'(idx0);
        end else begin
          idx1++;
          req1_writedata = 64'hB000 + 64'(idx1);
        end
        tick();
      end
      req0_write = 1'b0; req1_write = 1'b0;
    end

    // ---- Write held by csr_waitrequest for 5 cycles ----
    do_reset();
    req1_write = 1'b1; req1_address = 16'h0048; req1_writedata = 64'h55;
    csr_waitrequest = 1'b1;
    #1;
    check("bp_grant1", 64'(req1_waitrequest), 64'd0);
    tick();
    req1_write = 1'b0;
    req0_write = 1'b1; req0_address = 16'h0010; req0_writedata = 64'h66;
    for (int j = 0; j < 6; j++) begin
      csr_waitrequest = (j < 5);
      #1;
      check("bp_csr_write", 64'(csr_write), 64'd1);
      check("bp_csr_addr", 64'(csr_address), 64'h48);
      check("bp_no_grant0", 64'(req0_waitrequest), 64'd1);
      tick();
    end
    check("bp_done", 64'(csr_write), 64'd0);
    check("bp_next_grant0", 64'(req0_waitrequest), 64'd0);
    tick();
    req0_write = 1'b0;
    check("bp_next_addr", 64'(csr_address), 64'h10);
    tick();

    // ---- Read timeout on req1, late response dropped ----
    do_reset();
    req1_read = 1'b1; req1_address = 16'h0080;
    #1;
    check("to_grant1", 64'(req1_waitrequest), 64'd0);
    tick();                                                // A: csr_read accepted
    req1_read = 1'b0;
    check("to_csr_read", 64'(csr_read), 64'd1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("to_no_rv1_early", 64'(req1_readdatavalid), 64'd0);
    end
    tick();                                                // A+9
    check("to_rv1", 64'(req1_readdatavalid), 64'd1);
    check("to_data1", req1_readdata, BAD);
    check("to_rv0", 64'(req0_readdatavalid), 64'd0);
    check("to_tcnt", 64'(timeout_count), 64'd1);
    tick();                                                // A+10
    tick();                                                // A+11
    tick();                                                // A+12
    csr_readdatavalid = 1'b1; csr_readdata = 64'h777;
    tick();
    csr_readdatavalid = 1'b0;
    check("late_rv1", 64'(req1_readdatavalid), 64'd0);
    check("late_rv0", 64'(req0_readdatavalid), 64'd0);
    check("late_data1", req1_readdata, BAD);
    tick();
    check("late_rv1_b", 64'(req1_readdatavalid), 64'd0);

    // ---- Real data coincides with the timeout cycle ----
    req0_read = 1'b1; req0_address = 16'h0088;             // T
    #1;
    check("co_grant0", 64'(req0_waitrequest), 64'd0);
    tick();                                                // T+1 = A
    req0_read = 1'b0;
    for (int c = 2; c <= 8; c++) tick();                   // T+8
    tick();                                                // T+9: timer at last count
    csr_readdatavalid = 1'b1; csr_readdata = 64'hC0FFEE;
    tick();                                                // T+10
    csr_readdatavalid = 1'b0;
    check("co_rv0", 64'(req0_readdatavalid), 64'd1);
    check("co_data0", req0_readdata, 64'hC0FFEE);
    check("co_tcnt", 64'(timeout_count), 64'd1);
    tick();

    // ---- Reset pulsed during RD_WAIT ----
    req0_read = 1'b1; req0_address = 16'h0090;
    tick();                                                // ISSUE
    req0_read = 1'b0;
    tick();                                                // RD_WAIT
    tick();                                                // RD_WAIT
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_csr_addr", 64'(csr_address), 64'd0);
    check("ar_data0", req0_readdata, 64'd0);
    check("ar_tcnt", 64'(timeout_count), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    csr_readdatavalid = 1'b1; csr_readdata = 64'h999;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("ar_no_rv0", 64'(req0_readdatavalid), 64'd0);
      check("ar_no_rv1", 64'(req1_readdatavalid), 64'd0);
    end
    csr_readdatavalid = 1'b0;
    req0_read = 1'b1; req1_read = 1'b1;
    #1;
    check("ar_grant0", 64'(req0_waitrequest), 64'd0);
    check("ar_nogrant1", 64'(req1_waitrequest), 64'd1);
    tick();
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
